mul4_frame_counter: RTL and testbench

MUL4_FRAME_COUNTER -- requirements
Module: mul4_frame_counter

---
 rtl/mul4_frame_counter.sv | 72 +++++++
 tb/tb_mul4_frame_counter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mul4_frame_counter.sv
// Counts multiples of 4 per FRAME_LEN-sample frame; result registered on the edge taking the last sample.
// Backpressure: in_ready drops while a result waits in HOLD for cnt_ready.
module mul4_frame_counter #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       mul_flag,
  output logic       flag_valid,
  output logic [4:0] cnt,
  output logic       cnt_valid,
  input  logic       cnt_ready
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  state_t     state;
  logic [4:0] idx;
  logic [4:0] acc;
  logic       is_mul;
  logic [4:0] acc_next;

  assign in_ready = (state == COLLECT);
  assign is_mul   = (in_data[1:0] == 2'b00);
  assign acc_next = acc + {4'b0000, is_mul};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      idx        <= 5'd0;
      acc        <= 5'd0;
      cnt        <= 5'd0;
      cnt_valid  <= 1'b0;
      mul_flag   <= 1'b0;
      flag_valid <= 1'b0;
    end else begin
      flag_valid <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_valid) begin
            mul_flag   <= is_mul;
            flag_valid <= 1'b1;
            if (idx == LAST_IDX) begin
              // Result includes the closing sample; accumulator max is FRAME_LEN so 5 bits never wrap.
              cnt       <= acc_next;
              cnt_valid <= 1'b1;
              idx       <= 5'd0;
              acc       <= 5'd0;
              state     <= HOLD;
            end else begin
              idx <= idx + 5'd1;
              acc <= acc_next;
            end
          end
        end
        HOLD: begin
          if (cnt_ready) begin
            cnt_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_frame_counter.sv
// Directed bench for mul4_frame_counter with FRAME_LEN=8.
module tb_mul4_frame_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       mul_flag;
  logic       flag_valid;
  logic [4:0] cnt;
  logic       cnt_valid;
  logic       cnt_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul4_frame_counter #(.FRAME_LEN(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mul_flag   (mul_flag),
    .flag_valid (flag_valid),
    .cnt        (cnt),
    .cnt_valid  (cnt_valid),
    .cnt_ready  (cnt_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    cnt_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_cnt_valid",  cnt_valid,  0);
    chk("rst_cnt",        cnt,        0);
    chk("rst_mul_flag",   mul_flag,   0);
    chk("rst_flag_valid", flag_valid, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    // Frame 0..7 back to back, consumer always ready.
    cnt_ready = 1'b1;
    send(4'd0);
    chk("f1_s0_flag_valid", flag_valid, 1);
    chk("f1_s0_mul_flag",   mul_flag,   1);
    send(4'd1); chk("f1_s1_mul_flag", mul_flag, 0);
    send(4'd2); send(4'd3);
    send(4'd4); chk("f1_s4_mul_flag", mul_flag, 1);
    send(4'd5); send(4'd6);
    chk("f1_s6_cnt_valid", cnt_valid, 0);
    send(4'd7);
    chk("f1_cnt_valid", cnt_valid, 1);
    chk("f1_cnt",       cnt,       2);
    chk("f1_in_ready",  in_ready,  0);
    cyc();
    chk("f1_cnt_valid_clr", cnt_valid, 0);
    chk("f1_in_ready_back", in_ready,  1);
    chk("f1_cnt_kept",      cnt,       2);

    // All multiples, then none.
    for (int i = 0; i < 8; i++) send(4'd12);
    chk("f2_cnt_valid", cnt_valid, 1);
    chk("f2_cnt",       cnt,       8);
    cyc();
    send(4'd1); send(4'd2); send(4'd3); send(4'd5);
    send(4'd6); send(4'd7); send(4'd9); send(4'd10);
    chk("f3_cnt_valid", cnt_valid, 1);
    chk("f3_cnt",       cnt,       0);
    cyc();

    // Flag pulse behaviour.
    send(4'd4);
    chk("fl_4_mul_flag",   mul_flag,   1);
    chk("fl_4_flag_valid", flag_valid, 1);
    send(4'd5);
    chk("fl_5_mul_flag",   mul_flag,   0);
    chk("fl_5_flag_valid", flag_valid, 1);
    cyc();
    chk("fl_idle_flag_valid", flag_valid, 0);
    chk("fl_idle_mul_flag",   mul_flag,   0);

    // Finish this frame (4,5 + six zeros -> 7) and hold the result.
    for (int i = 0; i < 5; i++) send(4'd0);
    cnt_ready = 1'b0;
    send(4'd0);
    chk("bp_cnt_valid", cnt_valid, 1);
    chk("bp_cnt",       cnt,       7);
    in_valid = 1'b1;
    in_data  = 4'd5;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_in_ready",   in_ready,   0);
      chk("bp_cnt_stable", cnt,        7);
      chk("bp_cnt_valid1", cnt_valid,  1);
      chk("bp_no_accept",  flag_valid, 0);
      chk("bp_mul_held",   mul_flag,   1);
    end
    cnt_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("bp_release_cnt_valid", cnt_valid, 0);
    chk("bp_release_in_ready",  in_ready,  1);
    chk("bp_release_cnt",       cnt,       7);

    // Bubbles between every sample.
    send(4'd0);  cyc();
    chk("bub_flag_valid", flag_valid, 0);
    send(4'd4);  cyc();
    send(4'd8);  cyc();
    send(4'd12); cyc();
    send(4'd1);  cyc();
    send(4'd1);  cyc();
    send(4'd1);  cyc();
    chk("bub_7_cnt_valid", cnt_valid, 0);
    chk("bub_7_cnt",       cnt,       7);
    send(4'd1);
    chk("bub_8_cnt_valid", cnt_valid, 1);
    chk("bub_8_cnt",       cnt,       4);
    cyc();
    chk("bub_done_cnt_valid", cnt_valid, 0);

    // Mid-frame reset discards the partial frame.
    for (int i = 0; i < 5; i++) send(4'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_cnt",        cnt,        0);
    chk("mr_cnt_valid",  cnt_valid,  0);
    chk("mr_mul_flag",   mul_flag,   0);
    chk("mr_flag_valid", flag_valid, 0);
    chk("mr_in_ready",   in_ready,   1);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) send(4'd3);
    chk("mr_7_cnt_valid", cnt_valid, 0);
    send(4'd3);
    chk("mr_8_cnt_valid", cnt_valid, 1);
    chk("mr_8_cnt",       cnt,       0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
